pwm_bank: RTL and testbench
===========================

// Module: pwm_bank
// PURPOSE
//  Multi-channel PWM generator: NCH outputs share one period counter; each channel has its own duty.
//  Adds programmable period, edge-/center-aligned modes, per-channel polarity, and double-buffered
//  duty/period updates that take effect only at the period boundary (glitch-free).
//  Sits between the register/control logic and the LED/motor/audio pins; enable is the prescaler tick.
// PARAMETERS
//  NCH     4                 number of PWM channels (>=1)
//  CTRLEN  8                 counter/period width in bits
//  CHW     $clog2(NCH)>1?..:1  channel-select width (derived; do not override)
// PORTS
//  clk          in   1          system clock
//  rst          in   1          synchronous active-high reset
//  enable       in   1          count tick; counter advances only on cycles with enable=1
//  mode         in   1          pwm_pkg::pwm_mode_e: 0 EDGE (sawtooth), 1 CENTER (triangle)
//  period       in   CTRLEN     counter top value; shadowed, applied at boundary
//  duty_wr      in   1          write strobe for duty_val into shadow of channel duty_ch
//  duty_ch      in   CHW        target channel of duty_wr (values >= NCH ignored)
//  duty_val     in   CTRLEN+1   duty in counts; active iff counter < duty (>= period+1 -> 100%)
//  polarity     in   NCH        per-channel invert (1 = active-low output)
//  counter      out  CTRLEN     current counter value
//  period_start out  1          1-cycle pulse on the cycle the boundary update occurs
//  pwm_out      out  NCH        PWM outputs, registered
// BEHAVIOUR
//  Reset (rst=1 at clk edge): counter=0, dir=UP, per_act=all-ones, duty_sh/duty_act=0 all channels,
//   pwm_out=0, period_start=0. Reset mid-period aborts it immediately; no partial update retained.
//  Boundary B: an enable cycle where counter wraps (EDGE: counter==per_act -> 0; CENTER: counter==0
//   with dir=DOWN -> dir=UP). First enable after reset is also a boundary.
//  At B: per_act<=period; duty_act[i]<=duty_sh[i] for all i; period_start=1 for exactly that cycle.
//  EDGE: counter 0,1..per_act,0,... ; period = per_act+1 ticks.
//  CENTER: up 0..per_act, then down per_act-1..0; dir flips at per_act (->DOWN) and at 0 (->UP);
//   period = 2*per_act ticks; per_act=0 -> counter stays 0, B every enable tick.
//  enable=0: counter, dir, per_act, duty_act hold; duty_wr still updates shadow.
//  pwm_out[i] registered on same edge as counter: pwm_out[i] = (counter_next < duty_act_next[i]) ^ polarity[i],
//   so pwm_out always matches the visible counter/duty_act (zero relative latency) outside reset.
//  Compare is CTRLEN+1-bit unsigned: duty=0 -> 0%; duty>per_act -> 100% (per_act=all-ones supported).
//  duty_wr on the B cycle: written value lands in shadow AND active (write-through), visible same period.
//  duty_wr with duty_ch>=NCH: no effect. period change between boundaries: no effect until next B.
//  mode change: takes effect at next B; mode sampled into mode_act at B (EDGE after reset).
// STRUCTURE
//  pwm_pkg: typedef enum logic {PWM_EDGE, PWM_CENTER} pwm_mode_e; no other shared constants.
//  Sub-module pwm_chan_cmp (x NCH, generate loop): duty shadow/active regs, write-through logic,
//   comparator, polarity, output flop. Top holds counter, dir, per_act, mode_act, boundary detect.
// TESTING
//  1 EDGE, period=9, duty ch0=3, pol=0, enable=1 -> ch0 high for counter 0..2, low 3..9; period_start every 10 clks.
//  2 duty ch1 written 2->7 mid-period (counter=4) -> ch1 stays duty 2 until counter wraps, then 7; no glitch.
//  3 duty=0 and duty=256 (CTRLEN=8, period=255) -> constant 0 and constant 1; pol=1 inverts both.
//  4 CENTER, period=4, duty=2 -> counter 0,1,2,3,4,3,2,1,0..; out high at counter 0,1; B every 8 ticks.
//  5 enable toggled 1-of-3 cycles -> counter advances only on enable; pwm_out/period_start consistent.
//  6 rst asserted at counter=5 with duty_sh pending -> next cycle counter=0, pwm_out=0, shadow cleared.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types for the PWM bank: counter waveform selection.
package pwm_pkg;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

endpackage

// File: rtl/pwm_chan_cmp.sv
// One PWM channel: double-buffered duty (shadow/active), compare against next counter, polarity, output flop.
// Latency: output registered on the same edge as the counter, so pwm_out tracks the visible counter exactly.
// Backpressure: none; shadow writes always accepted, active duty only reloads at the period boundary.
module pwm_chan_cmp #(
    parameter int CTRLEN = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_hit,
    input  logic [CTRLEN:0]   duty_val,
    input  logic              boundary,
    input  logic [CTRLEN-1:0] counter_next,
    input  logic              polarity,
    output logic              pwm_out
);

    logic [CTRLEN:0] duty_sh;
    logic [CTRLEN:0] duty_act;
    logic [CTRLEN:0] duty_act_next;

    // A write landing on the boundary cycle goes straight into the active copy.
    always_comb begin
        duty_act_next = duty_act;
        if (boundary) begin
            duty_act_next = wr_hit ? duty_val : duty_sh;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            duty_sh  <= '0;
            duty_act <= '0;
            pwm_out  <= 1'b0;
        end else begin
            if (wr_hit) begin
                duty_sh <= duty_val;
            end
            duty_act <= duty_act_next;
            pwm_out  <= ({1'b0, counter_next} < duty_act_next) ^ polarity;
        end
    end

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM: shared edge/center-aligned period counter, per-channel duty and polarity.
// Latency: counter, period_start and pwm_out are registered together; updates apply at the period boundary.
// Backpressure: none; enable acts as the prescaler tick and simply gates counter advance.
module pwm_bank
    import pwm_pkg::*;
#(
    parameter int NCH    = 4,
    parameter int CTRLEN = 8,
    parameter int CHW    = ($clog2(NCH) > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  pwm_mode_e         mode,
    input  logic [CTRLEN-1:0] period,
    input  logic              duty_wr,
    input  logic [CHW-1:0]    duty_ch,
    input  logic [CTRLEN:0]   duty_val,
    input  logic [NCH-1:0]    polarity,
    output logic [CTRLEN-1:0] counter,
    output logic              period_start,
    output logic [NCH-1:0]    pwm_out
);

    logic [CTRLEN-1:0] per_act;
    logic [CTRLEN-1:0] per_nx;
    logic [CTRLEN-1:0] counter_nx;
    pwm_mode_e         mode_act;
    pwm_mode_e         mode_nx;
    logic              dir_dn;
    logic              dir_dn_nx;
    logic              first;
    logic              tick_b;

    always_comb begin
        tick_b = 1'b0;
        if (enable) begin
            if (first) begin
                tick_b = 1'b1;
            end else if (mode_act == PWM_EDGE) begin
                tick_b = (counter == per_act);
            end else begin
                tick_b = (counter == '0) && dir_dn;
            end
        end
    end

    always_comb begin
        counter_nx = counter;
        dir_dn_nx  = dir_dn;
        per_nx     = per_act;
        mode_nx    = mode_act;
        if (tick_b) begin
            per_nx  = period;
            mode_nx = mode;
            // Center mode restarts on the upslope so the 0 sample appears once per period;
            // a zero period parks the counter with dir down so every tick is a boundary.
            if (mode == PWM_CENTER) begin
                counter_nx = (period == '0) ? '0 : CTRLEN'(1);
                dir_dn_nx  = (period == '0);
            end else begin
                counter_nx = '0;
                dir_dn_nx  = 1'b0;
            end
        end else if (enable) begin
            if (mode_act == PWM_EDGE) begin
                counter_nx = counter + CTRLEN'(1);
            end else if (!dir_dn) begin
                if (counter == per_act) begin
                    dir_dn_nx  = 1'b1;
                    counter_nx = (per_act == '0) ? '0 : counter - CTRLEN'(1);
                end else begin
                    counter_nx = counter + CTRLEN'(1);
                end
            end else begin
                counter_nx = counter - CTRLEN'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            counter      <= '0;
            dir_dn       <= 1'b0;
            per_act      <= '1;
            mode_act     <= PWM_EDGE;
            first        <= 1'b1;
            period_start <= 1'b0;
        end else begin
            counter      <= counter_nx;
            dir_dn       <= dir_dn_nx;
            per_act      <= per_nx;
            mode_act     <= mode_nx;
            period_start <= tick_b;
            if (enable) begin
                first <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic wr_hit;
        assign wr_hit = duty_wr && (duty_ch == CHW'(i));

        pwm_chan_cmp #(
            .CTRLEN(CTRLEN)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .wr_hit      (wr_hit),
            .duty_val    (duty_val),
            .boundary    (tick_b),
            .counter_next(counter_nx),
            .polarity    (polarity[i]),
            .pwm_out     (pwm_out[i])
        );
    end

endmodule

// File: tb/tb_pwm_bank.sv
// Scoreboard bench for pwm_bank: each driven cycle pushes its hand-derived expected outputs,
// a monitor pops and compares shortly after every rising edge.
module tb_pwm_bank;
    import pwm_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    pwm_mode_e  mode;
    logic [7:0] period;
    logic       duty_wr;
    logic [1:0] duty_ch;
    logic [8:0] duty_val;
    logic [3:0] polarity;
    logic [7:0] counter;
    logic       period_start;
    logic [3:0] pwm_out;

    typedef struct {
        int         tid;
        logic [7:0] cnt;
        logic       ps;
        logic [3:0] pwm;
        logic [3:0] pm;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   ctbl[8] = '{1, 2, 3, 4, 3, 2, 1, 0};

    always #5 clk = ~clk;

    pwm_bank #(.NCH(4), .CTRLEN(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .mode        (mode),
        .period      (period),
        .duty_wr     (duty_wr),
        .duty_ch     (duty_ch),
        .duty_val    (duty_val),
        .polarity    (polarity),
        .counter     (counter),
        .period_start(period_start),
        .pwm_out     (pwm_out)
    );

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_chk++;
                if (counter !== e.cnt || period_start !== e.ps || (pwm_out & e.pm) !== (e.pwm & e.pm)) begin
                    n_err++;
                    $display("FAIL test%0d @%0t: counter=%0d period_start=%b pwm_out=%b (mask %b) required counter=%0d period_start=%b pwm_out=%b",
                             e.tid, $time, counter, period_start, pwm_out, e.pm, e.cnt, e.ps, e.pwm);
                end
            end
        end
    end

    // Called at a falling edge: drive inputs, queue the expected result of the next rising edge.
    task automatic step(input bit en, input bit wr, input logic [1:0] ch, input logic [8:0] val,
                        input int tid, input logic [7:0] c, input logic ps,
                        input logic [3:0] p, input logic [3:0] m);
        exp_t e;
        enable   = en;
        duty_wr  = wr;
        duty_ch  = ch;
        duty_val = val;
        e.tid = tid;
        e.cnt = c;
        e.ps  = ps;
        e.pwm = p;
        e.pm  = m;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic do_reset(input int tid);
        rst = 1'b1;
        step(1'b0, 1'b0, 2'd0, 9'd0, tid, 8'd0, 1'b0, 4'b0000, 4'hF);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; mode = PWM_EDGE; period = 8'd9;
        duty_wr = 1'b0; duty_ch = 2'd0; duty_val = 9'd0; polarity = 4'b0000;
        @(negedge clk);

        // 1: edge, period 9, ch0 duty 3; period changed to 5 mid-period applies at the next wrap.
        do_reset(1);
        step(1'b0, 1'b1, 2'd0, 9'd3, 1, 8'd0, 1'b0, 4'b0000, 4'hF);
        for (int k = 0; k < 32; k++) begin
            int c;
            c = (k < 20) ? (k % 10) : ((k - 20) % 6);
            if (k == 12) period = 8'd5;
            step(1'b1, 1'b0, 2'd0, 9'd0, 1, 8'(c), c == 0, {3'b000, c < 3}, 4'hF);
        end

        // 2: ch1 duty 2 -> 7 written at counter 4, then write-through of 4 on a wrap cycle.
        period = 8'd9;
        do_reset(2);
        step(1'b0, 1'b1, 2'd1, 9'd2, 2, 8'd0, 1'b0, 4'b0000, 4'hF);
        for (int k = 0; k < 30; k++) begin
            int c, d;
            c = k % 10;
            d = (k < 10) ? 2 : ((k < 20) ? 7 : 4);
            if (k == 5)
                step(1'b1, 1'b1, 2'd1, 9'd7, 2, 8'(c), c == 0, {2'b00, c < d, 1'b0}, 4'b0010);
            else if (k == 20)
                step(1'b1, 1'b1, 2'd1, 9'd4, 2, 8'(c), c == 0, {2'b00, c < d, 1'b0}, 4'b0010);
            else
                step(1'b1, 1'b0, 2'd0, 9'd0, 2, 8'(c), c == 0, {2'b00, c < d, 1'b0}, 4'b0010);
        end

        // 3: period 255, ch2 duty 0 and ch3 duty 256 stay constant; polarity then inverts them.
        period = 8'd255;
        do_reset(3);
        step(1'b0, 1'b1, 2'd3, 9'd256, 3, 8'd0, 1'b0, 4'b0000, 4'hF);
        for (int k = 0; k < 265; k++) begin
            if (k == 260) polarity = 4'b1100;
            step(1'b1, 1'b0, 2'd0, 9'd0, 3, 8'(k % 256), (k % 256) == 0,
                 (k < 260) ? 4'b1000 : 4'b0100, 4'hF);
        end
        polarity = 4'b0000;

        // 4: center mode, period 4, ch0 duty 2.
        period = 8'd4;
        mode   = PWM_CENTER;
        do_reset(4);
        step(1'b0, 1'b1, 2'd0, 9'd2, 4, 8'd0, 1'b0, 4'b0000, 4'hF);
        for (int k = 0; k < 20; k++) begin
            int c;
            c = ctbl[k % 8];
            step(1'b1, 1'b0, 2'd0, 9'd0, 4, 8'(c), (k % 8) == 0, {3'b000, c < 2}, 4'hF);
        end

        // 5: edge, period 4, enable on one cycle in three.
        period = 8'd4;
        mode   = PWM_EDGE;
        do_reset(5);
        step(1'b0, 1'b1, 2'd0, 9'd2, 5, 8'd0, 1'b0, 4'b0000, 4'hF);
        for (int k = 0; k < 30; k++) begin
            bit en;
            int t;
            en = (k % 3) == 0;
            t  = (k / 3) % 5;
            step(en, 1'b0, 2'd0, 9'd0, 5, 8'(t), en && (t == 0), {3'b000, t < 2}, 4'hF);
        end

        // 6: reset at counter 5 with a pending shadow write; shadow must come back cleared.
        period = 8'd9;
        do_reset(6);
        step(1'b0, 1'b1, 2'd0, 9'd3, 6, 8'd0, 1'b0, 4'b0000, 4'hF);
        for (int k = 0; k < 6; k++) begin
            if (k == 3)
                step(1'b1, 1'b1, 2'd0, 9'd8, 6, 8'(k), k == 0, {3'b000, k < 3}, 4'hF);
            else
                step(1'b1, 1'b0, 2'd0, 9'd0, 6, 8'(k), k == 0, {3'b000, k < 3}, 4'hF);
        end
        rst = 1'b1;
        step(1'b1, 1'b0, 2'd0, 9'd0, 6, 8'd0, 1'b0, 4'b0000, 4'hF);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, 2'd0, 9'd0, 6, 8'(k), k == 0, 4'b0000, 4'hF);
        end

        enable = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
